logistic_bank: RTL and testbench
================================

# logistic_bank

Parametrised successor to the single-trajectory logistic iterator. It holds CH logistic-map trajectories x(n+1) = mu·x(n)·(1−x(n)) in fixed point and advances all of them a programmable number of times through one shared, two-stage pipelined multiplier datapath. Run control uses a start/busy/done handshake. Results are exposed through a random-access read port for the display colour-select logic.

## Interface
Parameters:
- CH, default 4: number of trajectories (channels), 1..64.
- FRAC, default 16: fraction bits. ONE = 2^FRAC represents 1.0.
- ITER_W, default 9: width of the iteration count.
- CHW (derived), value max(1, clog2(CH)): channel index width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset. One clock; reset is asynchronous and active-high.
- start  in  1  run request. Sampled only in IDLE.
- mu  in  FRAC+2  map parameter, unsigned Q2.FRAC. Captured when start is accepted.
- seed  in  FRAC+1  base initial value, unsigned Q1.FRAC. Channel i starts at (seed + i) mod 2^(FRAC+1).
- times  in  ITER_W  number of map applications. Captured when start is accepted.
- busy  out  1  high from LOAD through RUN.
- done  out  1  one-cycle pulse when a run completes.
- rd_ch  in  CHW  read channel select.
- rd_data  out  FRAC+1  current state of channel rd_ch (combinational). Reads 0 if rd_ch ≥ CH.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 → LOAD.
  - Capture mu, seed and times into internal registers.
- LOAD (1 cycle):
  - Write state[i] = seed_r + i for all channels in parallel.
  - Clear the sweep counter.
  - times_r==0 → DONE; otherwise → RUN.
- RUN is organised as sweeps of CH+2 cycles:
  - Issue slots 0..CH−1 send channel p into the pipeline.
  - Then 2 drain cycles.
  - No new issue until the drain completes, so there is no read-after-write hazard for any CH.
- Datapath stage 1 (register):
  - p = floor(x·(ONE−x) / 2^FRAC), held at FRAC+1 bits.
  - x = ONE gives p = 0.
- Datapath stage 2 (register):
  - y = floor(mu_r·p / 2^FRAC), truncated to FRAC+1 bits.
  - Because mu < 4.0 and x(1−x) ≤ 0.25, y < ONE. No saturation is needed.
- Writeback: y is written to state[channel] 2 cycles after that channel's issue.
- On the last drain cycle the sweep counter increments. Counter == times_r → DONE; otherwise the next sweep begins.
- DONE (1 cycle): done=1, busy=0, then → IDLE.
- start is ignored outside IDLE, including in the DONE cycle. Captured mu, seed and times do not change mid-run.
- rd_data is valid at all times:
  - During RUN it shows the mix of already-updated and not-yet-updated channels of the current sweep.
  - After done it shows the final values.

## Timing
- Reset values: state IDLE, busy=0, done=0, all state[i]=0, pipeline registers 0, sweep counter 0.
  - rd_data therefore reads 0 until the first LOAD.
- RST asserted mid-run aborts immediately. No done pulse is produced.
- Cycle numbering: start is sampled at edge 0.
  - Cycle 1: LOAD, busy=1.
  - Cycle 2: RUN, or DONE if times=0.
- done is high in cycle 2 + times·(CH+2). busy is high in cycles 1 .. 1+times·(CH+2).
- Back-to-back runs: the earliest next start is sampled in the first IDLE cycle, i.e. the cycle after done.
- times = 2^ITER_W − 1 is legal. The sweep counter is ITER_W bits and never wraps before the compare.

## Test plan
With FRAC=16, CH=4, ITER_W=9:
- Fixed point: mu=0x20000 (2.0), seed=0x8000, times=1 → ch0=0x8000, ch1=0x7FFE. done is high in cycle 8.
- Zero iterations: times=0, seed=0x1234 → done high in cycle 2. Channels read 0x1234, 0x1235, 0x1236, 0x1237. busy is high only in cycle 1.
- Collapse: mu=0, times=5 → all channels 0. done in cycle 32.
- Handshake: pulse start again at cycles 3 and 8 of a times=3 run → ignored, and the single done stays in cycle 20. A start in cycle 21 is accepted, with LOAD in cycle 22.
- Reset: assert RST in cycle 10 of a times=100 run → busy=0, done=0, rd_data=0 for every rd_ch immediately, and no done follows. A later start runs normally.
- Cross-check: mu=0x3C000 (3.75), seed=0x4000, times=50 → each channel matches a bit-exact model of floor(mu·floor(x(ONE−x)/2^16)/2^16). rd_ch=5 reads 0.

Source files
------------

// File: rtl/logistic_bank.sv
// Bank of CH fixed-point logistic-map trajectories, x' = mu*x*(1-x), advanced
// in sweeps through one shared two-stage multiplier pipeline with a start/busy/done handshake.
module logistic_bank #(
  parameter  int CH     = 4,
  parameter  int FRAC   = 16,
  parameter  int ITER_W = 9,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [FRAC+1:0]   mu,
  input  logic [FRAC:0]     seed,
  input  logic [ITER_W-1:0] times,
  output logic              busy,
  output logic              done,
  input  logic [CHW-1:0]    rd_ch,
  output logic [FRAC:0]     rd_data
);

  localparam int            SW  = $clog2(CH + 2);
  localparam logic [FRAC:0] ONE = {1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            r_fsm;
  logic [FRAC+1:0]   r_mu;
  logic [FRAC:0]     r_seed;
  logic [ITER_W-1:0] r_times;
  logic [ITER_W-1:0] r_sweep;
  logic [SW-1:0]     r_slot;
  logic              r_busy;
  logic              r_done;
  logic [FRAC:0]     r_x [CH];

  logic              r_v1, r_v2;
  logic [CHW-1:0]    r_ch1, r_ch2;
  logic [FRAC:0]     r_p1, r_y2;

  logic                w_issue;
  logic                w_last_slot;
  logic [ITER_W-1:0]   w_sweep_nxt;
  logic [FRAC:0]       w_x;
  logic [FRAC:0]       w_om;
  logic [2*FRAC+1:0]   w_prod1;
  logic [FRAC:0]       w_p;
  logic [2*FRAC+2:0]   w_prod2;
  logic [FRAC:0]       w_y;

  assign w_issue     = (r_fsm == S_RUN) && (r_slot < SW'(CH));
  assign w_last_slot = (r_slot == SW'(CH + 1));
  assign w_sweep_nxt = r_sweep + 1'b1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_x = '0;
    for (int i = 0; i < CH; i++)
      if (r_slot == SW'(i)) w_x = r_x[i];
  end

  assign w_om    = ONE - w_x;
  assign w_prod1 = {{(FRAC+1){1'b0}}, w_x} * {{(FRAC+1){1'b0}}, w_om};
  assign w_p     = (FRAC+1)'(w_prod1 >> FRAC);
  assign w_prod2 = {{(FRAC+1){1'b0}}, r_mu} * {{(FRAC+2){1'b0}}, r_p1};
  assign w_y     = (FRAC+1)'(w_prod2 >> FRAC);

  // NOTE: sequential state always uses non-blocking assignments.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fsm   <= S_IDLE;
      r_mu    <= '0;
      r_seed  <= '0;
      r_times <= '0;
      r_sweep <= '0;
      r_slot  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mu    <= mu;
            r_seed  <= seed;
            r_times <= times;
            r_busy  <= 1'b1;
            r_fsm   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sweep <= '0;
          r_slot  <= '0;
          if (r_times == '0) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_fsm  <= S_DONE;
          end else begin
            r_fsm  <= S_RUN;
          end
        end
        S_RUN: begin
          // A sweep is CH issue slots plus two drain slots, so writes land before re-reads.
          if (w_last_slot) begin
            r_slot  <= '0;
            r_sweep <= w_sweep_nxt;
            if (w_sweep_nxt == r_times) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_fsm  <= S_DONE;
            end
          end else begin
            r_slot <= r_slot + 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_fsm  <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_ch1 <= '0;
      r_ch2 <= '0;
      r_p1  <= '0;
      r_y2  <= '0;
    end else begin
      r_v1  <= w_issue;
      r_ch1 <= CHW'(r_slot);
      r_p1  <= w_p;
      r_v2  <= r_v1;
      r_ch2 <= r_ch1;
      r_y2  <= w_y;
    end
  end

  // NOTE: the trajectory store is a flop array, reset so rd_data reads 0 before the first run.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CH; i++) r_x[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (r_fsm == S_LOAD)
          r_x[i] <= r_seed + (FRAC+1)'(i);
        else if (r_v2 && (r_ch2 == CHW'(i)))
          r_x[i] <= r_y2;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CH; i++)
      if (rd_ch == CHW'(i)) rd_data = r_x[i];
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_logistic_bank.sv
// Self-checking bench for logistic_bank: directed table, handshake/reset
// sequences, and randomized runs against an arithmetic reference model.
module tb_logistic_bank;

  localparam int     FRAC   = 16;
  localparam int     ITER_W = 9;
  localparam int     CH4    = 4;
  localparam int     CH5    = 5;
  localparam longint ONE    = longint'(1) << FRAC;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start, start5;
  logic [FRAC+1:0]   mu;
  logic [FRAC:0]     seed;
  logic [ITER_W-1:0] times;
  logic              busy4, done4, busy5, done5;
  logic [1:0]        rd_ch4;
  logic [2:0]        rd_ch5;
  logic [FRAC:0]     rd_data4, rd_data5;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  logistic_bank #(.CH(CH4), .FRAC(FRAC), .ITER_W(ITER_W)) u_dut4 (
    .CLK(CLK), .RST(RST), .start(start), .mu(mu), .seed(seed), .times(times),
    .busy(busy4), .done(done4), .rd_ch(rd_ch4), .rd_data(rd_data4)
  );

  logistic_bank #(.CH(CH5), .FRAC(FRAC), .ITER_W(ITER_W)) u_dut5 (
    .CLK(CLK), .RST(RST), .start(start5), .mu(mu), .seed(seed), .times(times),
    .busy(busy5), .done(done5), .rd_ch(rd_ch5), .rd_data(rd_data5)
  );

  typedef struct {
    logic [FRAC+1:0]     mu;
    logic [FRAC:0]       seed;
    int                  times;
    int                  done_cyc;
    logic [3:0][FRAC:0]  exp_ch;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: one map application straight from the fixed-point definition.
  function automatic longint map_step(input longint m, input longint x);
    longint p;
    p = (x * (ONE - x)) / ONE;
    return ((m * p) / ONE) % (2 * ONE);
  endfunction

  function automatic longint model_final(input longint m, input longint s, input int t, input int ch);
    longint x;
    x = (s + ch) % (2 * ONE);
    for (int k = 0; k < t; k++) x = map_step(m, x);
    return x;
  endfunction

  task automatic rd(input int sel, input int ch, output logic [FRAC:0] v);
    if (sel != 0) rd_ch5 = ch[2:0];
    else          rd_ch4 = ch[1:0];
    #1;
    v = (sel != 0) ? rd_data5 : rd_data4;
  endtask

  // Launch a run and watch busy/done cycle by cycle; cycle 1 is the LOAD cycle.
  task automatic run(input int sel, input logic [FRAC+1:0] m, input logic [FRAC:0] s, input int t,
                     output int done_cyc, output int busy_bad, output int ndone);
    int nch, last_busy, budget;
    logic b, d;
    nch       = (sel != 0) ? CH5 : CH4;
    last_busy = 1 + t * (nch + 2);
    budget    = last_busy + 8;
    mu    = m;
    seed  = s;
    times = t[ITER_W-1:0];
    if (sel != 0) start5 = 1'b1;
    else          start  = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; start5 = 1'b0;
    done_cyc = -1; busy_bad = 0; ndone = 0;
    for (int c = 1; c <= budget; c++) begin
      b = (sel != 0) ? busy5 : busy4;
      d = (sel != 0) ? done5 : done4;
      if (b !== (c <= last_busy)) busy_bad++;
      if (d === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_run(input string tag, input int sel, input logic [FRAC+1:0] m,
                           input logic [FRAC:0] s, input int t);
    int dc, bb, nd, nch;
    logic [FRAC:0] v;
    nch = (sel != 0) ? CH5 : CH4;
    run(sel, m, s, t, dc, bb, nd);
    check($sformatf("%s_done_cycle", tag), dc, 2 + t * (nch + 2));
    check($sformatf("%s_busy_window", tag), bb, 0);
    check($sformatf("%s_done_count", tag), nd, 1);
    for (int i = 0; i < nch; i++) begin
      rd(sel, i, v);
      check($sformatf("%s_ch%0d", tag, i), v, model_final(m, s, t, i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, bb, nd, w;
    logic [FRAC:0] v;
    logic [FRAC+1:0] rm;
    logic [FRAC:0]   rs;
    int              rt, sel;

    tbl[0] = '{mu: 18'h20000, seed: 17'h08000, times: 1, done_cyc: 8,
               exp_ch: {17'h07FFE, 17'h07FFE, 17'h07FFE, 17'h08000}};
    tbl[1] = '{mu: 18'h2A000, seed: 17'h01234, times: 0, done_cyc: 2,
               exp_ch: {17'h01237, 17'h01236, 17'h01235, 17'h01234}};
    tbl[2] = '{mu: 18'h00000, seed: 17'h03000, times: 5, done_cyc: 32,
               exp_ch: {17'h00000, 17'h00000, 17'h00000, 17'h00000}};
    tbl[3] = '{mu: 18'h10000, seed: 17'h00000, times: 2, done_cyc: 14,
               exp_ch: {17'h00001, 17'h00000, 17'h00000, 17'h00000}};
    tbl[4] = '{mu: 18'h20000, seed: 17'h0FFFD, times: 1, done_cyc: 8,
               exp_ch: {17'h00000, 17'h00000, 17'h00002, 17'h00004}};

    RST = 1'b1; start = 1'b0; start5 = 1'b0;
    mu = '0; seed = '0; times = '0; rd_ch4 = '0; rd_ch5 = '0;
    #2;
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    for (int i = 0; i < CH4; i++) begin
      rd(0, i, v);
      check($sformatf("rst_ch%0d", i), v, 0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int r = 0; r < 5; r++) begin
      run(0, tbl[r].mu, tbl[r].seed, tbl[r].times, dc, bb, nd);
      check($sformatf("tbl%0d_done_cycle", r), dc, tbl[r].done_cyc);
      check($sformatf("tbl%0d_busy_window", r), bb, 0);
      check($sformatf("tbl%0d_done_count", r), nd, 1);
      for (int i = 0; i < CH4; i++) begin
        rd(0, i, v);
        check($sformatf("tbl%0d_ch%0d", r, i), v, tbl[r].exp_ch[i]);
      end
    end

    // Handshake: starts during RUN and in the DONE cycle are ignored; mu change mid-run has no effect.
    @(posedge CLK); #1;
    mu = 18'h30000; seed = 17'h02000; times = 3;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    nd = 0; dc = -1;
    for (int c = 1; c <= 21; c++) begin
      start = (c == 3 || c == 8 || c == 20 || c == 21);
      if (c == 3)  mu = 18'h11111;
      if (c == 20) mu = 18'h30000;
      if (c == 21) check("hs_busy_c21", busy4, 1'b0);
      if (c <= 20 && done4 === 1'b1) begin
        nd++;
        dc = c;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    check("hs_done_cycle", dc, 20);
    check("hs_done_count", nd, 1);
    check("hs_load_c22", busy4, 1'b1);
    for (int i = 0; i < CH4; i++) begin
      rd(0, i, v);
      check($sformatf("hs_run1_ch%0d", i), v, model_final(18'h30000, 17'h02000, 3, i));
    end
    w = 0;
    while (done4 !== 1'b1 && w < 40) begin
      @(posedge CLK); #1;
      w++;
    end
    check("hs_run2_done", done4, 1'b1);
    for (int i = 0; i < CH4; i++) begin
      rd(0, i, v);
      check($sformatf("hs_run2_ch%0d", i), v, model_final(18'h30000, 17'h02000, 3, i));
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Reset mid-run: immediate clear, and no done afterwards.
    mu = 18'h38000; seed = 17'h01000; times = 100;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    #1;
    check("midrst_busy", busy4, 1'b0);
    check("midrst_done", done4, 1'b0);
    for (int i = 0; i < CH4; i++) begin
      rd(0, i, v);
      check($sformatf("midrst_ch%0d", i), v, 0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    nd = 0;
    for (int c = 0; c < 700; c++) begin
      if (done4 === 1'b1 || busy4 === 1'b1) nd++;
      @(posedge CLK); #1;
    end
    check("midrst_quiet", nd, 0);
    check_run("postrst", 0, 18'h38000, 17'h01000, 2);

    // Cross-check against the model, both bank sizes, plus out-of-range reads.
    check_run("xc4", 0, 18'h3C000, 17'h04000, 50);
    check_run("xc5", 1, 18'h3C000, 17'h04000, 50);
    for (int i = CH5; i < 8; i++) begin
      rd(1, i, v);
      check($sformatf("xc5_oob_rd%0d", i), v, 0);
    end

    for (int k = 0; k < 9; k++) begin
      sel = (k % 3 == 2) ? 1 : 0;
      rm  = (FRAC+2)'($urandom_range(0, 32'h3FFFF));
      rs  = (FRAC+1)'($urandom_range(0, 32'h10000 - CH5 + 1));
      rt  = $urandom_range(0, 12);
      check_run($sformatf("rnd%0d", k), sel, rm, rs, rt);
    end

    check_run("maxiter", 0, 18'h39000, 17'h07000, (1 << ITER_W) - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
